// File: rtl/oled_pkg.sv
// Shared types and constants for the SSD1331-class OLED SPI transmit engine.
package oled_pkg;

    typedef enum logic [2:0] {
        RES_LOW,
        RES_WAIT,
        IDLE,
        SHIFT,
        CS_HOLD,
        CS_GAP
    } state_t;

    localparam logic DC_CMD  = 1'b0;
    localparam logic DC_DATA = 1'b1;

    localparam int DEF_CLK_DIV      = 4;
    localparam int DEF_RESET_CYCLES = 25000;

endpackage

// File: rtl/oled_spi_tx_clk_en_div.sv
// Enable-style divider: one-cycle tick every DIV clocks, restarted by a synchronous clear.
module clk_en_div #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    output logic o_tick
);

    localparam int              CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]   LAST = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr || (r_cnt == LAST)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tick = (r_cnt == LAST) && !i_clr;

endmodule

// File: rtl/oled_spi_tx.sv
// SPI transmit engine for an SSD1331-class OLED: panel reset sequence, then
// MSB-first words with per-word D/C and CS framing, all outputs registered.
module oled_spi_tx
    import oled_pkg::*;
#(
    parameter int CLK_DIV      = DEF_CLK_DIV,
    parameter int DATA_W       = 8,
    parameter int RESET_CYCLES = DEF_RESET_CYCLES,
    parameter bit CPOL         = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_tx_valid,
    output logic              o_tx_ready,
    input  logic [DATA_W-1:0] i_tx_data,
    input  logic              i_tx_dc,
    input  logic              i_tx_last,
    output logic              o_init_done,
    output logic              o_busy,
    output logic              o_spi_sclk,
    output logic              o_spi_mosi,
    output logic              o_spi_dc,
    output logic              o_spi_cs_n,
    output logic              o_oled_res_n,
    output state_t            o_state
);

    localparam int              BW       = $clog2(DATA_W);
    localparam logic [BW-1:0]   LAST_BIT = BW'(DATA_W - 1);

    // Handshake: a word transfers on the rising clk edge where i_tx_valid and
    // o_tx_ready are both high; ready is only high in IDLE after init_done.
    state_t            r_state, w_state_nxt;
    logic [DATA_W-1:0] r_shift, w_shift_nxt;
    logic [BW-1:0]     r_bit_cnt, w_bit_nxt;
    logic              r_phase, w_phase_nxt;
    logic              r_last, w_last_nxt;
    logic              r_dc, w_dc_nxt;
    logic              r_cs_n, w_cs_n_nxt;
    logic              r_sclk, w_sclk_nxt;
    logic              r_tx_ready, r_busy, r_res_n, r_init_done;
    logic              w_res_tick, w_bit_tick, w_res_clr, w_bit_clr;

    assign w_res_clr = !((r_state == RES_LOW) || (r_state == RES_WAIT));
    assign w_bit_clr = !((r_state == SHIFT) || (r_state == CS_HOLD) || (r_state == CS_GAP));

    clk_en_div #(.DIV(RESET_CYCLES)) u_res_div (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_res_clr),
        .o_tick (w_res_tick)
    );

    clk_en_div #(.DIV(CLK_DIV)) u_bit_div (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_bit_clr),
        .o_tick (w_bit_tick)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_bit_nxt   = r_bit_cnt;
        w_phase_nxt = r_phase;
        w_last_nxt  = r_last;
        w_dc_nxt    = r_dc;
        w_cs_n_nxt  = r_cs_n;
        w_sclk_nxt  = r_sclk;
        case (r_state)
            RES_LOW:  if (w_res_tick) w_state_nxt = RES_WAIT;
            RES_WAIT: if (w_res_tick) w_state_nxt = IDLE;
            IDLE: begin
                if (i_tx_valid && r_tx_ready) begin
                    w_state_nxt = SHIFT;
                    w_shift_nxt = i_tx_data;
                    w_dc_nxt    = i_tx_dc;
                    w_last_nxt  = i_tx_last;
                    w_cs_n_nxt  = 1'b0;
                    w_bit_nxt   = '0;
                    w_phase_nxt = 1'b0;
                    w_sclk_nxt  = CPOL;
                end
            end
            SHIFT: begin
                if (w_bit_tick) begin
                    if (!r_phase) begin
                        w_sclk_nxt  = !CPOL;
                        w_phase_nxt = 1'b1;
                    end else begin
                        // Returning to CPOL closes the bit; mosi advances only here.
                        w_sclk_nxt  = CPOL;
                        w_phase_nxt = 1'b0;
                        if (r_bit_cnt == LAST_BIT) begin
                            w_state_nxt = r_last ? CS_HOLD : IDLE;
                        end else begin
                            w_bit_nxt   = r_bit_cnt + 1'b1;
                            w_shift_nxt = {r_shift[DATA_W-2:0], 1'b0};
                        end
                    end
                end
            end
            CS_HOLD: begin
                if (w_bit_tick) begin
                    w_cs_n_nxt  = 1'b1;
                    w_state_nxt = CS_GAP;
                end
            end
            CS_GAP:  if (w_bit_tick) w_state_nxt = IDLE;
            default: w_state_nxt = RES_LOW;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= RES_LOW;
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_phase     <= 1'b0;
            r_last      <= 1'b0;
            r_dc        <= DC_CMD;
            r_cs_n      <= 1'b1;
            r_sclk      <= CPOL;
            r_tx_ready  <= 1'b0;
            r_busy      <= 1'b1;
            r_res_n     <= 1'b0;
            r_init_done <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_shift     <= w_shift_nxt;
            r_bit_cnt   <= w_bit_nxt;
            r_phase     <= w_phase_nxt;
            r_last      <= w_last_nxt;
            r_dc        <= w_dc_nxt;
            r_cs_n      <= w_cs_n_nxt;
            r_sclk      <= w_sclk_nxt;
            r_tx_ready  <= (w_state_nxt == IDLE);
            r_busy      <= (w_state_nxt != IDLE);
            r_res_n     <= (w_state_nxt != RES_LOW);
            r_init_done <= r_init_done || (w_state_nxt == IDLE);
        end
    end

    assign o_tx_ready   = r_tx_ready;
    assign o_init_done  = r_init_done;
    assign o_busy       = r_busy;
    assign o_spi_sclk   = r_sclk;
    assign o_spi_mosi   = r_shift[DATA_W-1];
    assign o_spi_dc     = r_dc;
    assign o_spi_cs_n   = r_cs_n;
    assign o_oled_res_n = r_res_n;
    assign o_state      = r_state;

endmodule

// File: tb/tb_oled_spi_tx.sv
// Bench for oled_spi_tx: CPOL=0 instance with a bit-level monitor and word
// scoreboard, plus a CPOL=1 instance exercised by a hand-written sequence.
module tb_oled_spi_tx;
  import oled_pkg::*;

  localparam int CLK_DIV = 2;
  localparam int DATA_W  = 8;
  localparam int RC      = 10;

  typedef struct {
    logic [7:0] data;
    logic       dc;
    int         exp_cs_low;
    int         exp_gap;
    int         exp_rises;
  } vec_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // CPOL=0 instance
  logic       tx_valid = 1'b0, tx_dc = 1'b0, tx_last = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready, init_done, busy, sclk, mosi, dc, cs_n, res_n;
  state_t     state;

  // CPOL=1 instance
  logic       u1_valid = 1'b0, u1_dc = 1'b0, u1_last = 1'b0;
  logic [7:0] u1_data = 8'h00;
  logic       u1_ready, u1_init, u1_busy, u1_sclk, u1_mosi, u1_dcout, u1_cs_n, u1_res_n;
  state_t     u1_state;

  oled_spi_tx #(.CLK_DIV(CLK_DIV), .DATA_W(DATA_W), .RESET_CYCLES(RC), .CPOL(1'b0)) dut (
    .clk(clk), .rst(rst), .i_tx_valid(tx_valid), .o_tx_ready(tx_ready),
    .i_tx_data(tx_data), .i_tx_dc(tx_dc), .i_tx_last(tx_last),
    .o_init_done(init_done), .o_busy(busy), .o_spi_sclk(sclk), .o_spi_mosi(mosi),
    .o_spi_dc(dc), .o_spi_cs_n(cs_n), .o_oled_res_n(res_n), .o_state(state)
  );

  oled_spi_tx #(.CLK_DIV(CLK_DIV), .DATA_W(DATA_W), .RESET_CYCLES(RC), .CPOL(1'b1)) dut1 (
    .clk(clk), .rst(rst), .i_tx_valid(u1_valid), .o_tx_ready(u1_ready),
    .i_tx_data(u1_data), .i_tx_dc(u1_dc), .i_tx_last(u1_last),
    .o_init_done(u1_init), .o_busy(u1_busy), .o_spi_sclk(u1_sclk), .o_spi_mosi(u1_mosi),
    .o_spi_dc(u1_dcout), .o_spi_cs_n(u1_cs_n), .o_oled_res_n(u1_res_n), .o_state(u1_state)
  );

  int checks = 0;
  int errors = 0;
  logic [8:0] exp_q[$];
  int rise_cnt = 0, accept_cnt = 0, cs_falls = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // scoreboard: every accepted word is expected on the wire, MSB first
  always @(posedge clk) begin
    if (!rst && tx_valid && tx_ready) begin
      accept_cnt++;
      exp_q.push_back({tx_dc, tx_data});
      chk("accept_after_init", int'(init_done), 1);
    end
  end

  // wire monitor (CPOL=0): sample on rising SCLK, check framing rules
  logic       m_prev_sclk = 1'b0, m_prev_mosi = 1'b0, m_prev_dc = 1'b0, m_prev_cs = 1'b1;
  logic       m_dc = 1'b0;
  logic [7:0] m_word = 8'h00;
  logic [8:0] m_exp;
  int         m_bits = 0, m_hi = 0;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      m_bits = 0; m_hi = 0;
      m_prev_sclk = 1'b0; m_prev_mosi = 1'b0; m_prev_dc = 1'b0; m_prev_cs = 1'b1;
    end else begin
      if (sclk) m_hi++;
      else if (m_prev_sclk) begin
        chk("sclk_high_len", m_hi, CLK_DIV);
        m_hi = 0;
      end
      if (!m_prev_sclk && sclk) begin
        rise_cnt++;
        chk("cs_low_on_sample", int'(cs_n), 0);
        if (m_bits == 0) m_dc = dc;
        else chk("dc_stable_in_word", int'(dc), int'(m_dc));
        m_word = {m_word[6:0], mosi};
        m_bits++;
        if (m_bits == DATA_W) begin
          m_bits = 0;
          if (exp_q.size() == 0) begin
            chk("word_expected", 0, 1);
          end else begin
            m_exp = exp_q.pop_front();
            chk("word_data", int'(m_word), int'(m_exp[7:0]));
            chk("word_dc", int'(m_dc), int'(m_exp[8]));
          end
        end
      end
      if (mosi !== m_prev_mosi) chk("mosi_change_sclk_idle", int'(sclk), 0);
      if (cs_n !== m_prev_cs) chk("cs_change_sclk_idle", int'(sclk), 0);
      if (dc !== m_prev_dc) chk("dc_change_at_boundary", int'({sclk, m_bits != 0}), 0);
      if (m_prev_cs && !cs_n) cs_falls++;
      m_prev_sclk = sclk; m_prev_mosi = mosi; m_prev_dc = dc; m_prev_cs = cs_n;
    end
  end

  // driver tasks (entered and left on a falling edge)
  task automatic send_word(input logic [7:0] d, input logic wdc, input logic wlast);
    int n;
    n = 0;
    tx_valid = 1'b1; tx_data = d; tx_dc = wdc; tx_last = wlast;
    while (!tx_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("accept_in_budget", int'(tx_ready), 1);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic measure(output int low, output int gap);
    low = 0; gap = 0;
    for (int k = 0; k < 500 && !cs_n; k++) begin low++; @(negedge clk); end
    for (int k = 0; k < 500 && cs_n && !tx_ready; k++) begin gap++; @(negedge clk); end
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 2000 && !(tx_ready && cs_n); k++) @(negedge clk);
    chk("idle_reached", int'(tx_ready && cs_n), 1);
  endtask

  task automatic wait_init();
    for (int k = 0; k < 200 && !init_done; k++) @(negedge clk);
    chk("init_done_reached", int'(init_done), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t       tbl[5];
  int         n_low, n_wait, rdy_seen, low, gap, r0, a0, f0;
  logic [7:0] rd, u1_bits;
  logic       rdc, rl, u1_prev, u1_prev_mosi;
  int         u1_n;

  initial begin
    tbl[0] = '{8'hA5, 1'b0, 2*DATA_W*CLK_DIV + CLK_DIV, CLK_DIV, DATA_W};
    tbl[1] = '{8'h00, 1'b1, 2*DATA_W*CLK_DIV + CLK_DIV, CLK_DIV, DATA_W};
    tbl[2] = '{8'hFF, 1'b0, 2*DATA_W*CLK_DIV + CLK_DIV, CLK_DIV, DATA_W};
    tbl[3] = '{8'h3C, 1'b1, 2*DATA_W*CLK_DIV + CLK_DIV, CLK_DIV, DATA_W};
    tbl[4] = '{8'h81, 1'b1, 2*DATA_W*CLK_DIV + CLK_DIV, CLK_DIV, DATA_W};

    // reset values
    repeat (3) @(negedge clk);
    chk("rst_sclk", int'(sclk), 0);
    chk("rst_mosi", int'(mosi), 0);
    chk("rst_dc", int'(dc), 0);
    chk("rst_cs_n", int'(cs_n), 1);
    chk("rst_res_n", int'(res_n), 0);
    chk("rst_ready", int'(tx_ready), 0);
    chk("rst_init", int'(init_done), 0);
    chk("rst_busy", int'(busy), 1);
    chk("rst_state", int'(state), int'(RES_LOW));
    chk("rst_u1_sclk", int'(u1_sclk), 1);

    // power-up sequence timing
    rst = 1'b0;
    n_low = 0; n_wait = 0; rdy_seen = 0;
    for (int i = 0; i < 100 && !init_done; i++) begin
      if (!res_n) n_low++; else n_wait++;
      if (tx_ready) rdy_seen++;
      @(negedge clk);
    end
    chk("res_low_clocks", n_low, RC);
    chk("res_wait_clocks", n_wait, RC);
    chk("ready_before_init", rdy_seen, 0);
    chk("init_ready", int'(tx_ready), 1);
    chk("init_busy", int'(busy), 0);
    chk("init_res_n", int'(res_n), 1);

    // single isolated words
    for (int i = 0; i < 5; i++) begin
      r0 = rise_cnt;
      send_word(tbl[i].data, tbl[i].dc, 1'b1);
      tx_valid = 1'b0;
      measure(low, gap);
      chk("single_cs_low", low, tbl[i].exp_cs_low);
      chk("single_cs_gap", gap, tbl[i].exp_gap);
      chk("single_rises", rise_cnt - r0, tbl[i].exp_rises);
      chk("single_sb_empty", exp_q.size(), 0);
    end

    // burst: command then data, CS held across the boundary
    r0 = rise_cnt; f0 = cs_falls;
    send_word(8'h81, DC_CMD, 1'b0);
    send_word(8'hFF, DC_DATA, 1'b1);
    tx_valid = 1'b0;
    wait_idle();
    chk("burst_rises", rise_cnt - r0, 2 * DATA_W);
    chk("burst_cs_falls", cs_falls - f0, 1);
    chk("burst_sb_empty", exp_q.size(), 0);

    // reset in the middle of bit 4
    r0 = rise_cnt;
    send_word(8'hC3, 1'b0, 1'b1);
    tx_valid = 1'b0;
    for (int k = 0; k < 200 && (rise_cnt - r0) < 5; k++) @(negedge clk);
    chk("midrst_sclk_high", int'(sclk), 1);
    rst = 1'b1;
    #1;
    chk("midrst_cs_n", int'(cs_n), 1);
    chk("midrst_sclk", int'(sclk), 0);
    chk("midrst_res_n", int'(res_n), 0);
    chk("midrst_init", int'(init_done), 0);
    chk("midrst_ready", int'(tx_ready), 0);
    chk("midrst_mosi", int'(mosi), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_init();
    r0 = rise_cnt;
    send_word(8'h5A, 1'b1, 1'b1);
    tx_valid = 1'b0;
    wait_idle();
    chk("postrst_rises", rise_cnt - r0, DATA_W);
    chk("postrst_sb_empty", exp_q.size(), 0);

    // valid held through reset and across four back-to-back words
    rst = 1'b1;
    tx_valid = 1'b1; tx_data = 8'h12; tx_dc = 1'b0; tx_last = 1'b0;
    repeat (2) @(negedge clk);
    a0 = accept_cnt; r0 = rise_cnt; f0 = cs_falls;
    rst = 1'b0;
    send_word(8'h12, 1'b0, 1'b0);
    send_word(8'h34, 1'b1, 1'b0);
    send_word(8'hE7, 1'b1, 1'b0);
    send_word(8'h09, 1'b0, 1'b1);
    tx_valid = 1'b0;
    wait_idle();
    chk("b2b_accepts", accept_cnt - a0, 4);
    chk("b2b_rises", rise_cnt - r0, 4 * DATA_W);
    chk("b2b_cs_falls", cs_falls - f0, 1);
    chk("b2b_sb_empty", exp_q.size(), 0);

    // randomized words against the scoreboard
    a0 = accept_cnt; r0 = rise_cnt;
    for (int i = 0; i < 16; i++) begin
      rd  = 8'($urandom_range(0, 255));
      rdc = 1'($urandom_range(0, 1));
      rl  = (i == 15) ? 1'b1 : 1'($urandom_range(0, 1));
      send_word(rd, rdc, rl);
      tx_valid = 1'b0;
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_idle();
    chk("rand_accepts", accept_cnt - a0, 16);
    chk("rand_rises", rise_cnt - r0, 16 * DATA_W);
    chk("rand_sb_empty", exp_q.size(), 0);

    // CPOL=1 instance: idle high, sampled on the rising (second) edge
    for (int k = 0; k < 200 && !u1_init; k++) @(negedge clk);
    chk("u1_init", int'(u1_init), 1);
    chk("u1_idle_high", int'(u1_sclk), 1);
    u1_valid = 1'b1; u1_data = 8'h3C; u1_dc = 1'b1; u1_last = 1'b1;
    for (int k = 0; k < 100 && !u1_ready; k++) @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    u1_valid = 1'b0;
    chk("u1_cs_low", int'(u1_cs_n), 0);
    chk("u1_first_half_high", int'(u1_sclk), 1);
    u1_bits = 8'h00; u1_n = 0;
    u1_prev = u1_sclk; u1_prev_mosi = u1_mosi;
    for (int k = 0; k < 200 && !u1_cs_n; k++) begin
      @(negedge clk);
      if (!u1_prev && u1_sclk) begin
        u1_bits = {u1_bits[6:0], u1_prev_mosi};
        u1_n++;
      end
      u1_prev = u1_sclk; u1_prev_mosi = u1_mosi;
    end
    chk("u1_rises", u1_n, DATA_W);
    chk("u1_bits", int'(u1_bits), 32'h3C);
    chk("u1_end_sclk", int'(u1_sclk), 1);
    chk("u1_dc", int'(u1_dcout), 1);

    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
